// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side byte handshake and status flags (rx_parity_err only with UART_RX_PARITY_EN)
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ack;
    logic       rx_framing_err;
    logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    modport master (
`ifdef UART_RX_PARITY_EN
        output rx_parity_err,
`endif
        output rx_data, rx_data_valid, rx_framing_err, rx_overrun,
        input  rx_data_ack
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        input  rx_parity_err,
`endif
        input  rx_data, rx_data_valid, rx_framing_err, rx_overrun,
        output rx_data_ack
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver; define UART_RX_PARITY_EN for an even-parity bit after bit 7
module uart_rx #(
    parameter int BAUD_DIVISOR = 50000000 / 9600,
    parameter int OVERSAMPLE   = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rxd,
    uart_rx_if.master bus
);
    localparam int TICK_DIV = BAUD_DIVISOR / OVERSAMPLE;
    localparam int TW = $clog2(TICK_DIV > 1 ? TICK_DIV : 2);
    localparam int SW = $clog2(OVERSAMPLE > 1 ? OVERSAMPLE : 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic          prev_q, prev_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_data_valid_q, rx_data_valid_d;
    logic          rx_framing_err_q, rx_framing_err_d;
    logic          rx_overrun_q, rx_overrun_d;
    logic          done;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          rx_parity_err_q, rx_parity_err_d;
`endif

    logic rxd_s, fall, tick, mid, full;
    assign rxd_s = sync_q[1];
    assign fall  = prev_q & ~rxd_s;
    assign tick  = tick_cnt_q == TW'(TICK_DIV - 1);
    assign mid   = tick && samp_cnt_q == SW'(OVERSAMPLE / 2 - 1);
    assign full  = tick && samp_cnt_q == SW'(OVERSAMPLE - 1);

    // Synchronizer, tick timebase, frame FSM and output handshake next-state logic
    always_comb begin
        sync_d           = {sync_q[0], rxd};
        prev_d           = rxd_s;
        tick_cnt_d       = tick ? '0 : tick_cnt_q + 1'b1;
        samp_cnt_d       = tick ? samp_cnt_q + 1'b1 : samp_cnt_q;
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        shift_d          = shift_q;
        rx_framing_err_d = 1'b0;
        done             = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d        = par_bad_q;
        rx_parity_err_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: if (fall) begin
                state_d    = START;
                tick_cnt_d = '0;
                samp_cnt_d = '0;
                bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d  = 1'b0;
`endif
            end
            START: if (mid) begin
                state_d    = rxd_s ? IDLE : DATA;
                samp_cnt_d = '0;
            end
            DATA: if (full) begin
                shift_d    = {rxd_s, shift_q[7:1]};
                samp_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                state_d    = bit_cnt_q == 3'd7 ? PARITY : DATA;
`else
                state_d    = bit_cnt_q == 3'd7 ? STOP : DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (full) begin
                par_bad_d       = (^shift_q) ^ rxd_s;
                rx_parity_err_d = (^shift_q) ^ rxd_s;
                samp_cnt_d      = '0;
                state_d         = STOP;
            end
`endif
            STOP: if (full) begin
                samp_cnt_d       = '0;
                state_d          = rxd_s ? IDLE : BREAK;
                rx_framing_err_d = ~rxd_s;
`ifdef UART_RX_PARITY_EN
                done             = rxd_s & ~par_bad_q;
`else
                done             = rxd_s;
`endif
            end
            BREAK: if (rxd_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rx_data_d       = rx_data_q;
        rx_data_valid_d = rx_data_valid_q & ~bus.rx_data_ack;
        rx_overrun_d    = rx_overrun_q & ~(rx_data_valid_q & bus.rx_data_ack);
        if (done && (!rx_data_valid_q || bus.rx_data_ack)) begin
            rx_data_d       = shift_q;
            rx_data_valid_d = 1'b1;
        end else if (done) begin
            rx_overrun_d    = 1'b1;
        end
    end

    // State register with synchronous reset; synchronizer resets high so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            sync_q           <= 2'b11;
            prev_q           <= 1'b1;
            tick_cnt_q       <= '0;
            samp_cnt_q       <= '0;
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            rx_data_q        <= 8'h00;
            rx_data_valid_q  <= 1'b0;
            rx_framing_err_q <= 1'b0;
            rx_overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q        <= 1'b0;
            rx_parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            sync_q           <= sync_d;
            prev_q           <= prev_d;
            tick_cnt_q       <= tick_cnt_d;
            samp_cnt_q       <= samp_cnt_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            rx_data_q        <= rx_data_d;
            rx_data_valid_q  <= rx_data_valid_d;
            rx_framing_err_q <= rx_framing_err_d;
            rx_overrun_q     <= rx_overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q        <= par_bad_d;
            rx_parity_err_q  <= rx_parity_err_d;
`endif
        end
    end

    assign bus.rx_data        = rx_data_q;
    assign bus.rx_data_valid  = rx_data_valid_q;
    assign bus.rx_framing_err = rx_framing_err_q;
    assign bus.rx_overrun     = rx_overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.rx_parity_err  = rx_parity_err_q;
`endif
endmodule
